// File: rtl/mini_alu_exec_unit.sv
// mini_alu_exec_unit: registered multi-cycle execution unit for the MiniAlu datapath.
// Single-cycle ADD/SUB/STO/BLE/NOP, iterative shift-add MUL (DATA_W steps) and an
// optional restoring DIV (DATA_W steps) enabled by defining MINI_ALU_EXEC_DIV_EN.
// Valid/ready request handshake; one-cycle oValid pulse, no output backpressure.
module mini_alu_exec_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iValid,
  output logic              oReady,
  input  logic [3:0]        iOperation,
  input  logic [DATA_W-1:0] iOperandA,
  input  logic [DATA_W-1:0] iOperandB,
  input  logic [ADDR_W-1:0] iDestination,
  output logic              oValid,
  output logic [DATA_W-1:0] oResult,
  output logic [DATA_W-1:0] oResultHi,
  output logic [ADDR_W-1:0] oDestination,
  output logic              oWriteEnable,
  output logic              oBranchTaken,
  output logic              oCarry,
  output logic              oZero
);

  localparam logic [3:0] OpAdd = 4'd1;
  localparam logic [3:0] OpSub = 4'd2;
  localparam logic [3:0] OpMul = 4'd3;
  localparam logic [3:0] OpSto = 4'd4;
  localparam logic [3:0] OpBle = 4'd5;
`ifdef MINI_ALU_EXEC_DIV_EN
  localparam logic [3:0] OpDiv = 4'd6;
`endif

  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [CntW-1:0] LastIter = CntW'(DATA_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StMulRun,
    StDivRun,
    StDone
  } stateT;

  stateT stateQ, stateD;

  logic [CntW-1:0]     cntQ, cntD;
  // MUL: multiplicand. DIV: divisor.
  logic [DATA_W-1:0]   mcandQ, mcandD;
  // MUL: {partial product hi, remaining multiplier bits}. DIV: {remainder, dividend/quotient}.
  logic [2*DATA_W-1:0] workQ, workD;
  logic [ADDR_W-1:0]   destQ, destD;

  logic [DATA_W-1:0]   resultQ, resultHiQ;
  logic [ADDR_W-1:0]   destOutQ;
  logic                weQ, brQ, carryQ, zeroQ;

  logic                loadOut;
  logic [DATA_W-1:0]   newResult, newResultHi;
  logic [ADDR_W-1:0]   newDest;
  logic                newWe, newBr, newCarry;

  logic                accept;
  logic [DATA_W:0]     addSum, subDiff;
  logic [DATA_W:0]     mulSum;
  logic [2*DATA_W-1:0] mulNext;

  assign oReady = (stateQ == StIdle);
  assign oValid = (stateQ == StDone);
  assign accept = iValid & oReady;

  assign addSum  = {1'b0, iOperandA} + {1'b0, iOperandB};
  // Top bit of the widened difference is the borrow, i.e. A < B.
  assign subDiff = {1'b0, iOperandA} - {1'b0, iOperandB};

  // One shift-add step: conditionally add multiplicand to the high half, then shift right.
  assign mulSum  = {1'b0, workQ[2*DATA_W-1:DATA_W]} + (workQ[0] ? {1'b0, mcandQ} : '0);
  assign mulNext = {mulSum, workQ[DATA_W-1:1]};

`ifdef MINI_ALU_EXEC_DIV_EN
  logic [DATA_W:0]     remShift, divTrial;
  logic                divFits;
  logic [2*DATA_W-1:0] divNext;

  // One restoring step: shift next dividend bit into the remainder, subtract if it fits.
  // A zero divisor always fits, yielding all-ones quotient and remainder = A.
  assign remShift = workQ[2*DATA_W-1:DATA_W-1];
  assign divTrial = remShift - {1'b0, mcandQ};
  assign divFits  = (remShift >= {1'b0, mcandQ});
  assign divNext  = divFits ? {divTrial[DATA_W-1:0], workQ[DATA_W-2:0], 1'b1}
                            : {remShift[DATA_W-1:0], workQ[DATA_W-2:0], 1'b0};
`endif

  // Next-state, iteration datapath and output-load decode.
  always_comb begin
    stateD      = stateQ;
    cntD        = cntQ;
    mcandD      = mcandQ;
    workD       = workQ;
    destD       = destQ;
    loadOut     = 1'b0;
    newResult   = '0;
    newResultHi = '0;
    newDest     = destQ;
    newWe       = 1'b0;
    newBr       = 1'b0;
    newCarry    = 1'b0;

    case (stateQ)
      StIdle: begin
        if (accept) begin
          destD   = iDestination;
          newDest = iDestination;
          case (iOperation)
            OpAdd: begin
              stateD    = StDone;
              loadOut   = 1'b1;
              newResult = addSum[DATA_W-1:0];
              newCarry  = addSum[DATA_W];
              newWe     = 1'b1;
            end
            OpSub: begin
              stateD    = StDone;
              loadOut   = 1'b1;
              newResult = subDiff[DATA_W-1:0];
              newCarry  = subDiff[DATA_W];
              newWe     = 1'b1;
            end
            OpMul: begin
              stateD = StMulRun;
              cntD   = '0;
              mcandD = iOperandA;
              workD  = {{DATA_W{1'b0}}, iOperandB};
            end
            OpSto: begin
              stateD    = StDone;
              loadOut   = 1'b1;
              newResult = iOperandA;
              newWe     = 1'b1;
            end
            OpBle: begin
              stateD  = StDone;
              loadOut = 1'b1;
              newBr   = (iOperandB <= iOperandA);
            end
`ifdef MINI_ALU_EXEC_DIV_EN
            OpDiv: begin
              stateD = StDivRun;
              cntD   = '0;
              mcandD = iOperandB;
              workD  = {{DATA_W{1'b0}}, iOperandA};
            end
`endif
            default: begin
              // NOP and unused opcodes: pulse oValid with no write and no branch.
              stateD  = StDone;
              loadOut = 1'b1;
            end
          endcase
        end
      end

      StMulRun: begin
        workD = mulNext;
        cntD  = cntQ + 1'b1;
        if (cntQ == LastIter) begin
          stateD      = StDone;
          loadOut     = 1'b1;
          newResult   = mulNext[DATA_W-1:0];
          newResultHi = mulNext[2*DATA_W-1:DATA_W];
          newWe       = 1'b1;
        end
      end

`ifdef MINI_ALU_EXEC_DIV_EN
      StDivRun: begin
        workD = divNext;
        cntD  = cntQ + 1'b1;
        if (cntQ == LastIter) begin
          stateD      = StDone;
          loadOut     = 1'b1;
          newResult   = divNext[DATA_W-1:0];
          newResultHi = divNext[2*DATA_W-1:DATA_W];
          newCarry    = (mcandQ == '0);
          newWe       = 1'b1;
        end
      end
`endif

      StDone: begin
        stateD = StIdle;
      end

      default: begin
        stateD = StIdle;
      end
    endcase
  end

  // State and datapath registers; outputs only update on the edge entering StDone.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      stateQ    <= StIdle;
      cntQ      <= '0;
      mcandQ    <= '0;
      workQ     <= '0;
      destQ     <= '0;
      resultQ   <= '0;
      resultHiQ <= '0;
      destOutQ  <= '0;
      weQ       <= 1'b0;
      brQ       <= 1'b0;
      carryQ    <= 1'b0;
      zeroQ     <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      mcandQ <= mcandD;
      workQ  <= workD;
      destQ  <= destD;
      if (loadOut) begin
        resultQ   <= newResult;
        resultHiQ <= newResultHi;
        destOutQ  <= newDest;
        weQ       <= newWe;
        brQ       <= newBr;
        carryQ    <= newCarry;
        zeroQ     <= (newResult == '0);
      end
    end
  end

  assign oResult      = resultQ;
  assign oResultHi    = resultHiQ;
  assign oDestination = destOutQ;
  assign oWriteEnable = weQ;
  assign oBranchTaken = brQ;
  assign oCarry       = carryQ;
  assign oZero        = zeroQ;

endmodule

// File: tb/tb_mini_alu_exec_unit.sv
// Testbench for mini_alu_exec_unit (DATA_W=16, ADDR_W=8). Table-driven vectors plus
// hand-written sequences for handshake, operand latching and mid-operation reset.
// Opcode 6 expectations follow MINI_ALU_EXEC_DIV_EN.
module tb_mini_alu_exec_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        iValid = 1'b0;
  logic        oReady;
  logic [3:0]  iOperation = 4'd0;
  logic [15:0] iOperandA = 16'd0;
  logic [15:0] iOperandB = 16'd0;
  logic [7:0]  iDestination = 8'd0;
  logic        oValid;
  logic [15:0] oResult, oResultHi;
  logic [7:0]  oDestination;
  logic        oWriteEnable, oBranchTaken, oCarry, oZero;

  int checks = 0;
  int failures = 0;

  mini_alu_exec_unit #(.DATA_W(16), .ADDR_W(8)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iValid       (iValid),
    .oReady       (oReady),
    .iOperation   (iOperation),
    .iOperandA    (iOperandA),
    .iOperandB    (iOperandB),
    .iDestination (iDestination),
    .oValid       (oValid),
    .oResult      (oResult),
    .oResultHi    (oResultHi),
    .oDestination (oDestination),
    .oWriteEnable (oWriteEnable),
    .oBranchTaken (oBranchTaken),
    .oCarry       (oCarry),
    .oZero        (oZero)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  dest;
    logic [15:0] res;
    logic [15:0] hi;
    logic        we;
    logic        br;
    logic        carry;
    logic        zero;
    logic        chkRes;  // oResult/oZero are undefined for NOP-like opcodes
    int          lat;
  } vecT;

  localparam int NVec = 15;
  vecT vecs [NVec];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Step one clock; inputs and samples sit 1 time unit after the rising edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic waitReady(input string name);
    int n = 0;
    while (!oReady && n < 40) begin
      step();
      n++;
    end
    chk({name, "_ready_timeout"}, 64'(oReady), 64'd1);
  endtask

  // Present one request for exactly one edge, then scramble the inputs.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] d);
    iValid       = 1'b1;
    iOperation   = op;
    iOperandA    = a;
    iOperandB    = b;
    iDestination = d;
    step();
    iValid       = 1'b0;
    iOperation   = 4'd1;
    iOperandA    = 16'hDEAD;
    iOperandB    = 16'hBEEF;
    iDestination = 8'hEE;
  endtask

  // Latency counts edges from the accept edge; returns readyBad = cycles with oReady high.
  task automatic waitValid(output int lat, output int readyBad);
    lat = 1;
    readyBad = 0;
    while (!oValid && lat < 40) begin
      if (oReady) readyBad++;
      step();
      lat++;
    end
    if (oReady) readyBad++;
  endtask

  initial begin
    int lat;
    int readyBad;
    int pulses;
    string nm;

    vecs[0]  = '{4'd1, 16'hFFFF, 16'h0001, 8'h2A, 16'h0000, 16'h0000, 1, 0, 1, 1, 1, 1};
    vecs[1]  = '{4'd2, 16'h0003, 16'h0005, 8'h01, 16'hFFFE, 16'h0000, 1, 0, 1, 0, 1, 1};
    vecs[2]  = '{4'd5, 16'h0005, 16'h0005, 8'h02, 16'h0000, 16'h0000, 0, 1, 0, 1, 1, 1};
    vecs[3]  = '{4'd5, 16'h0005, 16'h0006, 8'h03, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 1};
    vecs[4]  = '{4'd4, 16'h1234, 16'h9999, 8'h04, 16'h1234, 16'h0000, 1, 0, 0, 0, 1, 1};
    vecs[5]  = '{4'd0, 16'h0007, 16'h0008, 8'h05, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1};
    vecs[6]  = '{4'd3, 16'hFFFF, 16'hFFFF, 8'h06, 16'h0001, 16'hFFFE, 1, 0, 0, 0, 1, 17};
    vecs[7]  = '{4'd3, 16'h00FF, 16'h0101, 8'h07, 16'hFFFF, 16'h0000, 1, 0, 0, 0, 1, 17};
`ifdef MINI_ALU_EXEC_DIV_EN
    vecs[8]  = '{4'd6, 16'h0064, 16'h0007, 8'h08, 16'h000E, 16'h0002, 1, 0, 0, 0, 1, 17};
    vecs[9]  = '{4'd6, 16'h1234, 16'h0000, 8'h09, 16'hFFFF, 16'h1234, 1, 0, 1, 0, 1, 17};
`else
    vecs[8]  = '{4'd6, 16'h0064, 16'h0007, 8'h08, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1};
    vecs[9]  = '{4'd6, 16'h1234, 16'h0000, 8'h09, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1};
`endif
    vecs[10] = '{4'd15, 16'h0001, 16'h0002, 8'h0A, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1};
    vecs[11] = '{4'd1, 16'h7FFF, 16'h0001, 8'h0B, 16'h8000, 16'h0000, 1, 0, 0, 0, 1, 1};
    vecs[12] = '{4'd2, 16'h0005, 16'h0003, 8'h0C, 16'h0002, 16'h0000, 1, 0, 0, 0, 1, 1};
    vecs[13] = '{4'd2, 16'h0005, 16'h0005, 8'h0D, 16'h0000, 16'h0000, 1, 0, 0, 1, 1, 1};
    vecs[14] = '{4'd3, 16'h0000, 16'h1234, 8'h0E, 16'h0000, 16'h0000, 1, 0, 0, 1, 1, 17};

    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b1;
    chk("reset_ready", 64'(oReady), 64'd1);
    chk("reset_valid", 64'(oValid), 64'd0);
    chk("reset_outputs",
        {24'd0, oResult, oResultHi, oDestination, oWriteEnable, oBranchTaken, oCarry, oZero},
        64'd0);

    // Table-driven vectors
    for (int i = 0; i < NVec; i++) begin
      nm = $sformatf("vec%0d", i);
      waitReady(nm);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest);
      waitValid(lat, readyBad);
      chk({nm, "_latency"}, 64'(lat), 64'(vecs[i].lat));
      chk({nm, "_ready_low"}, 64'(readyBad), 64'd0);
      chk({nm, "_flags"}, {60'd0, oWriteEnable, oBranchTaken, oCarry, oDestination == vecs[i].dest},
          {60'd0, vecs[i].we, vecs[i].br, vecs[i].carry, 1'b1});
      chk({nm, "_hi"}, 64'(oResultHi), 64'(vecs[i].hi));
      if (vecs[i].chkRes) begin
        chk({nm, "_result"}, {47'd0, oZero, oResult}, {47'd0, vecs[i].zero, vecs[i].res});
        step();
        chk({nm, "_hold"}, {47'd0, oValid, oResult}, {47'd0, 1'b0, vecs[i].res});
      end else begin
        step();
        chk({nm, "_pulse_once"}, 64'(oValid), 64'd0);
      end
    end

    // Held request during MUL is ignored; changed inputs do not disturb the latched MUL.
    waitReady("busy");
    iValid       = 1'b1;
    iOperation   = 4'd3;
    iOperandA    = 16'h0003;
    iOperandB    = 16'h0005;
    iDestination = 8'h11;
    step();
    iOperation   = 4'd1;
    iOperandA    = 16'h0001;
    iOperandB    = 16'h0001;
    iDestination = 8'h22;
    waitValid(lat, readyBad);
    chk("busy_mul_latency", 64'(lat), 64'd17);
    chk("busy_mul_result", {32'd0, oDestination, oResult, 8'd0}, {32'd0, 8'h11, 16'h000F, 8'd0});
    step();
    chk("busy_idle_gap", {62'd0, oValid, oReady}, {62'd0, 1'b0, 1'b1});
    step();
    iValid = 1'b0;
    chk("busy_add_result", {39'd0, oValid, oDestination, oResult}, {39'd0, 1'b1, 8'h22, 16'h0002});

    // Reset during MUL iteration 8 aborts without a pulse.
    step();
    waitReady("abort");
    issue(4'd3, 16'hFFFF, 16'hFFFF, 8'h33);
    repeat (7) step();
    chk("abort_still_busy", 64'(oReady), 64'd0);
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    chk("abort_outputs",
        {23'd0, oValid, oResult, oResultHi, oDestination, oWriteEnable, oBranchTaken, oCarry,
         oZero}, 64'd0);
    chk("abort_ready", 64'(oReady), 64'd1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (oValid) pulses++;
      step();
    end
    chk("abort_no_pulse", 64'(pulses), 64'd0);
    issue(4'd1, 16'h0002, 16'h0003, 8'h44);
    waitValid(lat, readyBad);
    chk("abort_add_latency", 64'(lat), 64'd1);
    chk("abort_add_result", {40'd0, oDestination, oResult}, {40'd0, 8'h44, 16'h0005});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
